// File: rtl/despachar_ativo.sv
// Dispatcher that walks a snapshot of candidate nodes in ascending index order
// and offers each one to a ready/valid consumer, reporting the count at the end.
module despachar_ativo #(
    parameter int NUM_NA         = 8,
    parameter int CRITERIO_WIDTH = 5,
    localparam int IDX_WIDTH     = $clog2(NUM_NA),
    localparam int CNT_WIDTH     = IDX_WIDTH + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ca_pronto_in,
    input  logic [CRITERIO_WIDTH-1:0]        ca_criterio_geral_in,
    input  logic [NUM_NA-1:0]                na_ativo_in,
    input  logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_in,
    input  logic                             aa_atualizar_in,
    input  logic                             da_aceito_in,
    output logic                             da_valido_o,
    output logic [IDX_WIDTH-1:0]             da_indice_o,
    output logic [CRITERIO_WIDTH-1:0]        da_criterio_o,
    output logic                             da_fim_o,
    output logic                             da_ocupado_o,
    output logic [CNT_WIDTH-1:0]             da_total_o
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NA - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        OFFER,
        DONE
    } state_t;

    state_t                    state;
    state_t                    state_n;
    logic [IDX_WIDTH-1:0]      ptr;
    logic [IDX_WIDTH-1:0]      ptr_n;
    logic [NUM_NA-1:0]         mask;
    logic [NUM_NA-1:0]         mask_n;
    logic [NUM_NA-1:0]         candidatos;
    logic                      valido_n;
    logic [IDX_WIDTH-1:0]      indice_n;
    logic [CRITERIO_WIDTH-1:0] criterio_n;
    logic                      fim_n;
    logic                      ocupado_n;
    logic [CNT_WIDTH-1:0]      total_n;

    // A node is a candidate when it is active and its criterion equals the minimum.
    always_comb begin
        candidatos = '0;
        for (int i = 0; i < NUM_NA; i++) begin
            candidatos[i] = na_ativo_in[i] &&
                (na_criterio_in[CRITERIO_WIDTH*i +: CRITERIO_WIDTH] == ca_criterio_geral_in);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            mask          <= '0;
            da_valido_o   <= 1'b0;
            da_indice_o   <= '0;
            da_criterio_o <= '1;
            da_fim_o      <= 1'b0;
            da_ocupado_o  <= 1'b0;
            da_total_o    <= '0;
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            mask          <= mask_n;
            da_valido_o   <= valido_n;
            da_indice_o   <= indice_n;
            da_criterio_o <= criterio_n;
            da_fim_o      <= fim_n;
            da_ocupado_o  <= ocupado_n;
            da_total_o    <= total_n;
        end
    end

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        mask_n     = mask;
        valido_n   = da_valido_o;
        indice_n   = da_indice_o;
        criterio_n = da_criterio_o;
        fim_n      = 1'b0;
        total_n    = da_total_o;

        unique case (state)
            IDLE: begin
                if (ca_pronto_in) begin
                    state_n    = SCAN;
                    ptr_n      = '0;
                    mask_n     = candidatos;
                    criterio_n = ca_criterio_geral_in;
                    total_n    = '0;
                end
            end
            SCAN: begin
                if (mask[ptr]) begin
                    state_n  = OFFER;
                    valido_n = 1'b1;
                    indice_n = ptr;
                end else if (ptr == LAST_IDX) begin
                    state_n = DONE;
                    fim_n   = 1'b1;
                end else begin
                    ptr_n = ptr + 1'b1;
                end
            end
            OFFER: begin
                if (da_valido_o && da_aceito_in) begin
                    mask_n[da_indice_o] = 1'b0;
                    total_n             = da_total_o + 1'b1;
                    valido_n            = 1'b0;
                    if (da_indice_o == LAST_IDX) begin
                        state_n = DONE;
                        fim_n   = 1'b1;
                    end else begin
                        state_n = SCAN;
                        ptr_n   = da_indice_o + 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Abort overrides everything, including a transfer in the same cycle.
        if (aa_atualizar_in) begin
            state_n  = IDLE;
            mask_n   = '0;
            valido_n = 1'b0;
            fim_n    = 1'b0;
            total_n  = da_total_o;
        end

        ocupado_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_despachar_ativo.sv
// Self-checking bench for despachar_ativo: directed scenarios plus randomized
// rounds checked against a cycle-count model derived from the candidate list.
module tb_despachar_ativo;

    localparam int NUM_NA    = 8;
    localparam int W         = 5;
    localparam int IDX_WIDTH = 3;
    localparam int CNT_WIDTH = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  ca_pronto_in;
    logic [W-1:0]          ca_criterio_geral_in;
    logic [NUM_NA-1:0]     na_ativo_in;
    logic [NUM_NA*W-1:0]   na_criterio_in;
    logic                  aa_atualizar_in;
    logic                  da_aceito_in;
    logic                  da_valido_o;
    logic [IDX_WIDTH-1:0]  da_indice_o;
    logic [W-1:0]          da_criterio_o;
    logic                  da_fim_o;
    logic                  da_ocupado_o;
    logic [CNT_WIDTH-1:0]  da_total_o;

    int n_checks = 0;
    int n_pass   = 0;

    despachar_ativo #(.NUM_NA(NUM_NA), .CRITERIO_WIDTH(W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ca_pronto_in         (ca_pronto_in),
        .ca_criterio_geral_in (ca_criterio_geral_in),
        .na_ativo_in          (na_ativo_in),
        .na_criterio_in       (na_criterio_in),
        .aa_atualizar_in      (aa_atualizar_in),
        .da_aceito_in         (da_aceito_in),
        .da_valido_o          (da_valido_o),
        .da_indice_o          (da_indice_o),
        .da_criterio_o        (da_criterio_o),
        .da_fim_o             (da_fim_o),
        .da_ocupado_o         (da_ocupado_o),
        .da_total_o           (da_total_o)
    );

    always #5 clk = ~clk;

    // Outputs are read 1 time unit after the rising edge; inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_node(input int i, input logic act, input logic [W-1:0] crit);
        na_ativo_in[i]           = act;
        na_criterio_in[W*i +: W] = crit;
    endtask

    task automatic clear_inputs();
        ca_pronto_in         = 1'b0;
        ca_criterio_geral_in = '0;
        aa_atualizar_in      = 1'b0;
        da_aceito_in         = 1'b0;
        for (int i = 0; i < NUM_NA; i++) set_node(i, 1'b0, 5'd7);
    endtask

    task automatic scramble();
        na_ativo_in          = NUM_NA'($urandom);
        na_criterio_in       = {$urandom, $urandom};
        ca_criterio_geral_in = W'($urandom_range(0, 3));
        ca_pronto_in         = ($urandom_range(0, 5) == 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        n_checks++; if (da_valido_o !== 1'b0) $display("[TB] FAIL reset_valido: got %0b expected 0", da_valido_o); else n_pass++;
        n_checks++; if (da_indice_o !== 3'd0) $display("[TB] FAIL reset_indice: got %0d expected 0", da_indice_o); else n_pass++;
        n_checks++; if (da_criterio_o !== 5'h1f) $display("[TB] FAIL reset_criterio: got %0h expected 1f", da_criterio_o); else n_pass++;
        n_checks++; if (da_fim_o !== 1'b0) $display("[TB] FAIL reset_fim: got %0b expected 0", da_fim_o); else n_pass++;
        n_checks++; if (da_ocupado_o !== 1'b0) $display("[TB] FAIL reset_ocupado: got %0b expected 0", da_ocupado_o); else n_pass++;
        n_checks++; if (da_total_o !== 4'd0) $display("[TB] FAIL reset_total: got %0d expected 0", da_total_o); else n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int got[$];
        int fims;
        int fim_k;
        got.delete();
        fims  = 0;
        fim_k = -1;
        clear_inputs();
        set_node(1, 1'b1, 5'd3);
        set_node(2, 1'b1, 5'd3);
        set_node(5, 1'b1, 5'd3);
        ca_criterio_geral_in = 5'd3;
        da_aceito_in         = 1'b1;
        ca_pronto_in         = 1'b1;
        step();
        ca_pronto_in = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (da_valido_o === 1'b1 && da_aceito_in === 1'b1) got.push_back(int'(da_indice_o));
            if (da_fim_o === 1'b1) begin
                fims++;
                if (fim_k < 0) fim_k = k;
            end
            step();
        end
        n_checks++; if (got.size() != 3) $display("[TB] FAIL basic_count: got %0d offers expected 3", got.size()); else n_pass++;
        if (got.size() == 3) begin
            n_checks++; if (got[0] != 1 || got[1] != 2 || got[2] != 5) $display("[TB] FAIL basic_order: got %0d,%0d,%0d expected 1,2,5", got[0], got[1], got[2]); else n_pass++;
        end
        n_checks++; if (fims != 1) $display("[TB] FAIL basic_fim_pulses: got %0d expected 1", fims); else n_pass++;
        n_checks++; if (fim_k != 12) $display("[TB] FAIL basic_fim_cycle: got %0d expected 12", fim_k); else n_pass++;
        n_checks++; if (da_total_o !== 4'd3) $display("[TB] FAIL basic_total: got %0d expected 3", da_total_o); else n_pass++;
        n_checks++; if (da_criterio_o !== 5'd3) $display("[TB] FAIL basic_criterio: got %0d expected 3", da_criterio_o); else n_pass++;
        da_aceito_in = 1'b0;
    endtask

    task automatic test_empty();
        int valids;
        int fim_k;
        valids = 0;
        fim_k  = -1;
        clear_inputs();
        ca_criterio_geral_in = 5'd31;
        ca_pronto_in         = 1'b1;
        step();
        ca_pronto_in = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (da_valido_o === 1'b1) valids++;
            if (da_fim_o === 1'b1 && fim_k < 0) fim_k = k;
            step();
        end
        n_checks++; if (valids != 0) $display("[TB] FAIL empty_valido: got %0d valid cycles expected 0", valids); else n_pass++;
        n_checks++; if (fim_k != 9) $display("[TB] FAIL empty_fim_cycle: got %0d expected 9", fim_k); else n_pass++;
        n_checks++; if (da_total_o !== 4'd0) $display("[TB] FAIL empty_total: got %0d expected 0", da_total_o); else n_pass++;
    endtask

    task automatic test_latency();
        int first_k;
        first_k = -1;
        clear_inputs();
        set_node(0, 1'b1, 5'd2);
        ca_criterio_geral_in = 5'd2;
        ca_pronto_in         = 1'b1;
        step();
        ca_pronto_in = 1'b0;
        for (int k = 1; k <= 6 && first_k < 0; k++) begin
            if (da_valido_o === 1'b1) first_k = k;
            else step();
        end
        n_checks++; if (first_k != 2) $display("[TB] FAIL latency: got %0d expected 2", first_k); else n_pass++;
        n_checks++; if (da_indice_o !== 3'd0) $display("[TB] FAIL latency_indice: got %0d expected 0", da_indice_o); else n_pass++;
        aa_atualizar_in = 1'b1;
        step();
        aa_atualizar_in = 1'b0;
        n_checks++; if (da_ocupado_o !== 1'b0) $display("[TB] FAIL latency_abort_ocupado: got %0b expected 0", da_ocupado_o); else n_pass++;
    endtask

    task automatic test_stall();
        int first_k;
        int bad;
        first_k = -1;
        bad     = 0;
        clear_inputs();
        set_node(7, 1'b1, 5'd4);
        ca_criterio_geral_in = 5'd4;
        ca_pronto_in         = 1'b1;
        step();
        ca_pronto_in = 1'b0;
        for (int k = 1; k <= 20 && first_k < 0; k++) begin
            if (da_valido_o === 1'b1) first_k = k;
            else step();
        end
        n_checks++; if (first_k != 9) $display("[TB] FAIL stall_first_valid: got %0d expected 9", first_k); else n_pass++;
        for (int s = 0; s < 10; s++) begin
            step();
            if (da_valido_o !== 1'b1 || da_indice_o !== 3'd7) bad++;
        end
        n_checks++; if (bad != 0) $display("[TB] FAIL stall_hold: got %0d unstable cycles expected 0", bad); else n_pass++;
        da_aceito_in = 1'b1;
        step();
        da_aceito_in = 1'b0;
        n_checks++; if (da_fim_o !== 1'b1 || da_valido_o !== 1'b0) $display("[TB] FAIL stall_done: got fim=%0b valido=%0b expected fim=1 valido=0", da_fim_o, da_valido_o); else n_pass++;
        n_checks++; if (da_total_o !== 4'd1) $display("[TB] FAIL stall_total: got %0d expected 1", da_total_o); else n_pass++;
        step();
        n_checks++; if (da_fim_o !== 1'b0 || da_ocupado_o !== 1'b0) $display("[TB] FAIL stall_idle: got fim=%0b ocupado=%0b expected 0 0", da_fim_o, da_ocupado_o); else n_pass++;
    endtask

    task automatic test_abort();
        int events;
        events = 0;
        clear_inputs();
        set_node(1, 1'b1, 5'd6);
        set_node(2, 1'b1, 5'd6);
        set_node(5, 1'b1, 5'd6);
        ca_criterio_geral_in = 5'd6;
        ca_pronto_in         = 1'b1;
        step();
        ca_pronto_in = 1'b0;
        for (int b = 0; b < 20 && da_valido_o !== 1'b1; b++) step();
        n_checks++; if (da_valido_o !== 1'b1 || da_indice_o !== 3'd1) $display("[TB] FAIL abort_first: got valido=%0b indice=%0d expected 1 1", da_valido_o, da_indice_o); else n_pass++;
        da_aceito_in = 1'b1;
        step();
        da_aceito_in = 1'b0;
        for (int b = 0; b < 20 && da_valido_o !== 1'b1; b++) step();
        n_checks++; if (da_valido_o !== 1'b1 || da_indice_o !== 3'd2) $display("[TB] FAIL abort_second: got valido=%0b indice=%0d expected 1 2", da_valido_o, da_indice_o); else n_pass++;
        da_aceito_in    = 1'b1;
        aa_atualizar_in = 1'b1;
        step();
        da_aceito_in    = 1'b0;
        aa_atualizar_in = 1'b0;
        n_checks++; if (da_valido_o !== 1'b0 || da_ocupado_o !== 1'b0) $display("[TB] FAIL abort_idle: got valido=%0b ocupado=%0b expected 0 0", da_valido_o, da_ocupado_o); else n_pass++;
        n_checks++; if (da_total_o !== 4'd1) $display("[TB] FAIL abort_total: got %0d expected 1", da_total_o); else n_pass++;
        for (int s = 0; s < 12; s++) begin
            if (da_fim_o === 1'b1 || da_valido_o === 1'b1 || da_ocupado_o === 1'b1) events++;
            step();
        end
        n_checks++; if (events != 0) $display("[TB] FAIL abort_quiet: got %0d active cycles expected 0", events); else n_pass++;
    endtask

    task automatic test_ignore_pronto();
        clear_inputs();
        set_node(3, 1'b1, 5'd2);
        set_node(6, 1'b1, 5'd9);
        ca_criterio_geral_in = 5'd9;
        ca_pronto_in         = 1'b1;
        step();
        ca_criterio_geral_in = 5'd2;
        step();
        ca_pronto_in = 1'b0;
        for (int b = 0; b < 20 && da_valido_o !== 1'b1; b++) step();
        n_checks++; if (da_valido_o !== 1'b1 || da_indice_o !== 3'd6) $display("[TB] FAIL ignore_indice: got valido=%0b indice=%0d expected 1 6", da_valido_o, da_indice_o); else n_pass++;
        n_checks++; if (da_criterio_o !== 5'd9) $display("[TB] FAIL ignore_criterio: got %0d expected 9", da_criterio_o); else n_pass++;
        da_aceito_in = 1'b1;
        for (int b = 0; b < 20 && da_fim_o !== 1'b1; b++) step();
        da_aceito_in = 1'b0;
        n_checks++; if (da_fim_o !== 1'b1 || da_total_o !== 4'd1) $display("[TB] FAIL ignore_total: got fim=%0b total=%0d expected 1 1", da_fim_o, da_total_o); else n_pass++;
        step();
        ca_pronto_in    = 1'b1;
        aa_atualizar_in = 1'b1;
        step();
        ca_pronto_in    = 1'b0;
        aa_atualizar_in = 1'b0;
        n_checks++; if (da_ocupado_o !== 1'b0) $display("[TB] FAIL abort_vs_pronto: got ocupado=%0b expected 0", da_ocupado_o); else n_pass++;
        step();
        n_checks++; if (da_ocupado_o !== 1'b0 || da_valido_o !== 1'b0) $display("[TB] FAIL abort_vs_pronto_hold: got ocupado=%0b valido=%0b expected 0 0", da_ocupado_o, da_valido_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int got[$];
        int fims;
        got.delete();
        fims = 0;
        clear_inputs();
        set_node(4, 1'b1, 5'd1);
        ca_criterio_geral_in = 5'd1;
        ca_pronto_in         = 1'b1;
        step();
        ca_pronto_in = 1'b0;
        for (int b = 0; b < 20 && da_valido_o !== 1'b1; b++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (da_valido_o !== 1'b0 || da_indice_o !== 3'd0 || da_fim_o !== 1'b0) $display("[TB] FAIL midreset_outputs: got valido=%0b indice=%0d fim=%0b expected 0 0 0", da_valido_o, da_indice_o, da_fim_o); else n_pass++;
        n_checks++; if (da_criterio_o !== 5'h1f || da_ocupado_o !== 1'b0 || da_total_o !== 4'd0) $display("[TB] FAIL midreset_state: got criterio=%0h ocupado=%0b total=%0d expected 1f 0 0", da_criterio_o, da_ocupado_o, da_total_o); else n_pass++;
        clear_inputs();
        set_node(0, 1'b1, 5'd5);
        set_node(3, 1'b1, 5'd5);
        ca_criterio_geral_in = 5'd5;
        da_aceito_in         = 1'b1;
        ca_pronto_in         = 1'b1;
        step();
        ca_pronto_in = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (da_valido_o === 1'b1) got.push_back(int'(da_indice_o));
            if (da_fim_o === 1'b1) fims++;
            step();
        end
        da_aceito_in = 1'b0;
        n_checks++; if (got.size() != 2 || fims != 1) $display("[TB] FAIL midreset_round: got %0d offers %0d fims expected 2 1", got.size(), fims); else n_pass++;
        if (got.size() == 2) begin
            n_checks++; if (got[0] != 0 || got[1] != 3) $display("[TB] FAIL midreset_order: got %0d,%0d expected 0,3", got[0], got[1]); else n_pass++;
        end
        n_checks++; if (da_total_o !== 4'd2) $display("[TB] FAIL midreset_total: got %0d expected 2", da_total_o); else n_pass++;
    endtask

    // Each index gets one scan cycle; each candidate adds its offer cycles (wait + 1).
    task automatic test_random();
        for (int r = 0; r < 40; r++) begin
            int q[$];
            int w[$];
            int acc;
            int k;
            int target;
            int fim_k;
            logic [NUM_NA-1:0] act;
            logic [W-1:0] crit;
            logic [W-1:0] mn;
            q.delete();
            w.delete();
            acc = 0;
            clear_inputs();
            act = NUM_NA'($urandom);
            mn  = W'($urandom_range(0, 3));
            for (int i = 0; i < NUM_NA; i++) begin
                crit = W'($urandom_range(0, 3));
                set_node(i, act[i], crit);
                if (act[i] && crit == mn) q.push_back(i);
            end
            foreach (q[j]) w.push_back(int'($urandom_range(0, 3)));
            ca_criterio_geral_in = mn;
            ca_pronto_in         = 1'b1;
            step();
            k = 1;
            foreach (q[j]) begin
                target = 2 + q[j] + acc;
                while (k < target) begin
                    n_checks++; if (da_valido_o !== 1'b0 || da_fim_o !== 1'b0) $display("[TB] FAIL rnd_idle r=%0d k=%0d: got valido=%0b fim=%0b expected 0 0", r, k, da_valido_o, da_fim_o); else n_pass++;
                    scramble();
                    step();
                    k++;
                end
                n_checks++; if (da_valido_o !== 1'b1 || da_indice_o !== IDX_WIDTH'(q[j]) || da_criterio_o !== mn) $display("[TB] FAIL rnd_offer r=%0d k=%0d: got valido=%0b indice=%0d criterio=%0d expected 1 %0d %0d", r, k, da_valido_o, da_indice_o, da_criterio_o, q[j], mn); else n_pass++;
                for (int s = 0; s < w[j]; s++) begin
                    scramble();
                    da_aceito_in = 1'b0;
                    step();
                    k++;
                    n_checks++; if (da_valido_o !== 1'b1 || da_indice_o !== IDX_WIDTH'(q[j])) $display("[TB] FAIL rnd_hold r=%0d k=%0d: got valido=%0b indice=%0d expected 1 %0d", r, k, da_valido_o, da_indice_o, q[j]); else n_pass++;
                end
                scramble();
                da_aceito_in = 1'b1;
                step();
                k++;
                da_aceito_in = 1'b0;
                acc += w[j] + 1;
            end
            fim_k = 1 + NUM_NA + acc;
            while (k < fim_k) begin
                n_checks++; if (da_valido_o !== 1'b0 || da_fim_o !== 1'b0) $display("[TB] FAIL rnd_tail r=%0d k=%0d: got valido=%0b fim=%0b expected 0 0", r, k, da_valido_o, da_fim_o); else n_pass++;
                scramble();
                step();
                k++;
            end
            n_checks++; if (da_fim_o !== 1'b1 || da_total_o !== CNT_WIDTH'(q.size()) || da_criterio_o !== mn) $display("[TB] FAIL rnd_done r=%0d: got fim=%0b total=%0d criterio=%0d expected 1 %0d %0d", r, da_fim_o, da_total_o, da_criterio_o, q.size(), mn); else n_pass++;
            ca_pronto_in = 1'b0;
            step();
            n_checks++; if (da_fim_o !== 1'b0 || da_ocupado_o !== 1'b0) $display("[TB] FAIL rnd_idle_after r=%0d: got fim=%0b ocupado=%0b expected 0 0", r, da_fim_o, da_ocupado_o); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_latency();
        test_stall();
        test_abort();
        test_ignore_pronto();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
